// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel datapath output packer.
package sobel_pkg;

  localparam int PIX_W           = 8;
  localparam int WORD_W          = 32;
  localparam int PIX_PER_GROUP   = 4;
  localparam int WORDS_PER_GROUP = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WORD0 = 3'd1,
    WORD1 = 3'd2,
    WORD2 = 3'd3,
    DONE  = 3'd4
  } pack_state_t;

endpackage

// File: rtl/gray_word_mux.sv
// Combinational word selector: builds the little-endian RGB word for the
// current WORD state from the four captured gray pixels ([3] streams first).
module gray_word_mux
  import sobel_pkg::*;
(
  input  pack_state_t                              state_i,
  input  logic [PIX_PER_GROUP-1:0][PIX_W-1:0]      pix_i,
  output logic [WORD_W-1:0]                        word_o
);

  // Byte stream p3,p3,p3,p2,p2,p2,p1,p1,p1,p0,p0,p0 cut into three words;
  // outside the WORD states the bus is driven to zero.
  always_comb begin
    word_o = '0;
    case (state_i)
      WORD0:   word_o = {pix_i[2], pix_i[3], pix_i[3], pix_i[3]};
      WORD1:   word_o = {pix_i[1], pix_i[1], pix_i[2], pix_i[2]};
      WORD2:   word_o = {pix_i[0], pix_i[0], pix_i[0], pix_i[1]};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/gray_rgb_packer.sv
// Gray-to-RGB packer: captures four gray pixels on gray_done and streams
// them as three 32-bit R=G=B words over valid/ready.
// Optional build macro GRAY_PACK_THRESH_EN binarizes pixels at capture
// (>= THRESHOLD -> 8'hFF, else 8'h00).
module gray_rgb_packer
  import sobel_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESHOLD = 8'd128
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [PIX_PER_GROUP-1:0][PIX_W-1:0]  gray_pixel,
  input  logic                                 gray_done,
  output logic                                 pack_ready,
  output logic [WORD_W-1:0]                    out_word,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 pack_done,
  output logic                                 overrun
);

`ifdef GRAY_PACK_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  pack_state_t                             state_q, state_d;
  logic [PIX_PER_GROUP-1:0][PIX_W-1:0]     pix_q, pix_d;
  logic                                    overrun_q, overrun_d;
  logic                                    capture;

  assign capture = (state_q == IDLE) && gray_done;

  // Next state: capture in IDLE, advance a word per accepted handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gray_done) state_d = WORD0;
      WORD0:   if (out_ready) state_d = WORD1;
      WORD1:   if (out_ready) state_d = WORD2;
      WORD2:   if (out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture data, optionally binarized; held unchanged outside a capture.
  always_comb begin
    pix_d = pix_q;
    if (capture) begin
      for (int i = 0; i < PIX_PER_GROUP; i++) begin
        if (THRESH_EN)
          pix_d[i] = (gray_pixel[i] >= THRESHOLD) ? 8'hFF : 8'h00;
        else
          pix_d[i] = gray_pixel[i];
      end
    end
  end

  // Sticky overrun: a group pulse while busy is dropped and flagged.
  always_comb begin
    overrun_d = overrun_q | (gray_done && (state_q != IDLE));
  end

  // State, pixel and overrun registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      overrun_q <= overrun_d;
    end
  end

  gray_word_mux u_mux (
    .state_i (state_q),
    .pix_i   (pix_q),
    .word_o  (out_word)
  );

  // All outputs decode registered state only.
  assign out_valid  = (state_q == WORD0) || (state_q == WORD1) || (state_q == WORD2);
  assign pack_ready = (state_q == IDLE);
  assign pack_done  = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: doc/gray_rgb_packer.md
# gray_rgb_packer

Output-side counterpart to the grayscale stage in the Sobel edge-detection datapath. It captures a group of four 8-bit gray pixels on a one-cycle `gray_done` pulse. It then expands each pixel to a 24-bit gray triplet (R=G=B) and streams the 12 resulting bytes as three little-endian 32-bit words over a valid/ready interface toward the image write-back master. Busy status, group completion and overrun are reported to the controller.

## Interface
- `THRESHOLD`, default 8'd128: binarization threshold; used only when `GRAY_PACK_THRESH_EN` is defined.
- `clk` in 1: system clock, rising-edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `gray_pixel` in [3:0][7:0]: gray pixel group; `[3]` is the first pixel in stream order. Valid only in the cycle `gray_done`=1.
- `gray_done` in 1: one-cycle pulse that qualifies `gray_pixel`.
- `pack_ready` out 1: high only in IDLE; a group can be captured.
- `out_word` out 32: packed output word.
- `out_valid` out 1: `out_word` is valid.
- `out_ready` in 1: downstream accepts `out_word` when `out_valid`=1 at the same clock edge.
- `pack_done` out 1: one-cycle pulse after the third word has been accepted.
- `overrun` out 1: sticky; set when `gray_done` arrives while not in IDLE.

## Operation
- States: IDLE, WORD0, WORD1, WORD2, DONE.
- IDLE: `pack_ready`=1. On `gray_done`=1, register all four pixels (after optional threshold) and go to WORD0.
- WORDk (k = 0..2): `out_valid`=1 and `out_word` = word k.
  - If `out_ready`=1, advance: WORD0 -> WORD1 -> WORD2 -> DONE.
  - Otherwise hold the state with `out_word` stable.
- DONE: `pack_done`=1, `out_valid`=0. Go to IDLE unconditionally.
- Byte stream: b0..b11 = p3,p3,p3, p2,p2,p2, p1,p1,p1, p0,p0,p0. Word k = {b(4k+3), b(4k+2), b(4k+1), b(4k)}.
  - word0 = {p2,p3,p3,p3}
  - word1 = {p1,p1,p2,p2}
  - word2 = {p0,p0,p0,p1}
- `gray_done` outside IDLE: the pulse is ignored, the captured data is unchanged, and `overrun` is set. `overrun` is cleared only by reset.
- `out_ready` asserted while `out_valid`=0 has no effect.
- No arithmetic beyond the threshold compare; every path is 8 bits wide with no width growth.

## Timing
- Reset values: state IDLE, captured pixels 0, `out_word` 0, `out_valid` 0, `pack_done` 0, `overrun` 0, `pack_ready` 1.
- `gray_done` at edge N -> `out_valid`=1 with word0 from cycle N+1.
- With `out_ready` held high, words appear in cycles N+1, N+2 and N+3. `pack_done` is high in cycle N+4, and `pack_ready` returns in cycle N+5.
- Minimum group period is 5 cycles. The grayscale stage needs at least 6 cycles per group, so back-to-back groups never overrun.
- Stalls: each cycle of `out_ready`=0 in a WORD state adds one cycle of latency. Word content and `out_valid` stay stable.
- `out_word`, `out_valid`, `pack_ready` and `pack_done` are decoded from registered state and data only. There is no combinational path from `out_ready` or `gray_done` to any output.
- Reset asserted mid-group: all outputs return to reset values immediately (asynchronously). The partial group is discarded, and no `pack_done` is issued for it.

## Configuration
- `GRAY_PACK_THRESH_EN` defined: each pixel is binarized at capture. Pixels >= `THRESHOLD` become 8'hFF; all others become 8'h00.
- `GRAY_PACK_THRESH_EN` undefined: pixels are captured unmodified and `THRESHOLD` is unused.
- Latency and handshake behaviour are identical in both builds.

## Structure
- Shared package `sobel_pkg`:
  - `pack_state_t` enum (IDLE, WORD0, WORD1, WORD2, DONE)
  - constants `PIX_W`=8, `WORD_W`=32, `PIX_PER_GROUP`=4, `WORDS_PER_GROUP`=3
- Sub-module `gray_word_mux`: purely combinational. It selects word0/1/2 from the four registered pixels given the state.
- The top level holds the FSM, capture registers, threshold logic and the overrun flag.

## Test plan
- Reset, then idle: `pack_ready`=1, `out_valid`=0, `out_word`=0, `overrun`=0.
- Group p3..p0 = 0x11,0x22,0x33,0x44 with `out_ready`=1:
  - outputs 0x22111111, 0x33332222, 0x44444433 in consecutive cycles
  - `pack_done` pulse one cycle later, then `pack_ready`=1
- Same group with `out_ready` low for 3 cycles during WORD1: 0x33332222 is held stable for 4 cycles and accepted once. Total latency grows by 3 cycles.
- `gray_done` pulsed during WORD1: the stream remains 0x22111111, 0x33332222, 0x44444433 and `overrun`=1 until reset.
- `n_rst` pulsed low during WORD2: outputs are zero immediately, there is no `pack_done`, and the next group packs correctly.
- `GRAY_PACK_THRESH_EN` build, `THRESHOLD`=128, pixels 0x7F,0x80,0x00,0xFF: outputs 0xFF000000, 0x0000FFFF, 0xFFFFFF00.
